// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
// Carries the decoded control bundle, valid bit and destination register from
// ID through DEPTH downstream stages. Also produces the load-use stall, applies
// the branch flush to the stage-1 capture, generates forwarding selects for the
// two ID source operands and keeps a saturating count of inserted bubbles.
module ctrl_pipe_chain #(
  parameter int CTRL_W   = 12,
  parameter int RD_W     = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_BIT = 0,
  parameter int RFE_BIT  = 1,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [CTRL_W-1:0]       id_ctrl,
  input  logic [RD_W-1:0]         id_rd,
  input  logic [RD_W-1:0]         id_rn,
  input  logic [RD_W-1:0]         id_rm,
  input  logic                    id_rn_use,
  input  logic                    id_rm_use,
  input  logic                    flush,
  output logic                    stall_out,
  output logic [DEPTH-1:0]        stg_valid,
  output logic [DEPTH*CTRL_W-1:0] stg_ctrl,
  output logic [DEPTH*RD_W-1:0]   stg_rd,
  output logic [SEL_W-1:0]        fwd_rn_sel,
  output logic [SEL_W-1:0]        fwd_rm_sel,
  output logic [15:0]             bubble_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Stage registers; array index 0 is stage 1 (EX), index DEPTH-1 is stage DEPTH.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [RD_W-1:0]   rd_d   [DEPTH];
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  // Per-stage "this stage writes the register read by rn / rm" flags.
  logic [DEPTH-1:0]  rn_hit;
  logic [DEPTH-1:0]  rm_hit;

  logic              ex_is_load;
  logic              rn_load_hit;
  logic              rm_load_hit;
  logic              hazard;
  logic              stall;
  logic              bubble_now;

  // Youngest (lowest-numbered) matching stage, 0 when nothing matches.
  function automatic logic [SEL_W-1:0] youngest_hit(input logic [DEPTH-1:0] hit);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel = SEL_W'(k + 1);
      end
    end
    return sel;
  endfunction

  // Writer match per stage, and output packing of every stage register.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign rn_hit[gi] = valid_q[gi] & ctrl_q[gi][RFE_BIT] & (rd_q[gi] == id_rn);
      assign rm_hit[gi] = valid_q[gi] & ctrl_q[gi][RFE_BIT] & (rd_q[gi] == id_rm);
      assign stg_valid[gi]                   = valid_q[gi];
      assign stg_ctrl[gi*CTRL_W +: CTRL_W]   = ctrl_q[gi];
      assign stg_rd[gi*RD_W +: RD_W]         = rd_q[gi];
    end
  endgenerate

  // Load-use hazard: a used source depends on the load currently in stage 1.
  always_comb begin
    ex_is_load  = valid_q[0] & ctrl_q[0][LOAD_BIT];
    rn_load_hit = id_rn_use & rn_hit[0] & ex_is_load;
    rm_load_hit = id_rm_use & rm_hit[0] & ex_is_load;
    hazard      = id_valid & (rn_load_hit | rm_load_hit);
    // A flush already kills the ID instruction, so stalling it is pointless.
    stall       = hazard & ~flush;
    bubble_now  = flush | stall;
  end

  assign stall_out = stall;

  // Forwarding selects; a stage-1 load hides older writers of the same register.
  always_comb begin
    fwd_rn_sel = '0;
    fwd_rm_sel = '0;
    if (!stall) begin
      if (id_rn_use && !(rn_hit[0] && ex_is_load)) begin
        fwd_rn_sel = youngest_hit(rn_hit);
      end
      if (id_rm_use && !(rm_hit[0] && ex_is_load)) begin
        fwd_rm_sel = youngest_hit(rm_hit);
      end
    end
  end

  // Stage-1 capture or bubble; every older stage just takes its predecessor.
  always_comb begin
    valid_d[0] = 1'b0;
    ctrl_d[0]  = '0;
    rd_d[0]    = '0;
    if (!bubble_now && id_valid) begin
      valid_d[0] = 1'b1;
      ctrl_d[0]  = id_ctrl;
      rd_d[0]    = id_rd;
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      ctrl_d[k]  = ctrl_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
  end

  // Saturating bubble counter next state.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_now && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // State registers; reset discards all in-flight entries and the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= '0;
      bubble_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        rd_q[k]   <= rd_d[k];
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Testbench for ctrl_pipe_chain (default parameters: CTRL_W=12, RD_W=4, DEPTH=3).
// A stage-list model predicts every output each cycle; directed scenarios add
// hand-computed expectations at the interesting points.
module tb_ctrl_pipe_chain;

  localparam int CW = 12;
  localparam int RW = 4;
  localparam int DP = 3;
  localparam int SW = 2;

  logic            clk;
  logic            reset;
  logic            id_valid;
  logic [CW-1:0]   id_ctrl;
  logic [RW-1:0]   id_rd;
  logic [RW-1:0]   id_rn;
  logic [RW-1:0]   id_rm;
  logic            id_rn_use;
  logic            id_rm_use;
  logic            flush;
  logic            stall_out;
  logic [DP-1:0]   stg_valid;
  logic [DP*CW-1:0] stg_ctrl;
  logic [DP*RW-1:0] stg_rd;
  logic [SW-1:0]   fwd_rn_sel;
  logic [SW-1:0]   fwd_rm_sel;
  logic [15:0]     bubble_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  ctrl_pipe_chain dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_ctrl    (id_ctrl),
    .id_rd      (id_rd),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_rn_use  (id_rn_use),
    .id_rm_use  (id_rm_use),
    .flush      (flush),
    .stall_out  (stall_out),
    .stg_valid  (stg_valid),
    .stg_ctrl   (stg_ctrl),
    .stg_rd     (stg_rd),
    .fwd_rn_sel (fwd_rn_sel),
    .fwd_rm_sel (fwd_rm_sel),
    .bubble_cnt (bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model: list of in-flight instructions ----------------
  bit          m_v [1:DP];
  logic [CW-1:0] m_c [1:DP];
  logic [RW-1:0] m_r [1:DP];
  int          m_cnt;

  function automatic bit m_writes(int k, logic [RW-1:0] src);
    return m_v[k] && m_c[k][1] && (m_r[k] == src);
  endfunction

  function automatic bit m_stall();
    bit dep;
    dep = (id_rn_use && m_writes(1, id_rn) && m_c[1][0]) ||
          (id_rm_use && m_writes(1, id_rm) && m_c[1][0]);
    return id_valid && dep && !flush;
  endfunction

  function automatic logic [SW-1:0] m_sel(logic [RW-1:0] src, bit used);
    if (!used || m_stall()) return '0;
    for (int k = 1; k <= DP; k++) begin
      if (m_writes(k, src)) begin
        if (k == 1 && m_c[1][0]) return '0;
        return SW'(k);
      end
    end
    return '0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int k = 1; k <= DP; k++) begin
          m_v[k] = 0; m_c[k] = '0; m_r[k] = '0;
        end
        m_cnt = 0;
      end else begin
        bit bub;
        bub = flush || m_stall();
        for (int k = DP; k >= 2; k--) begin
          m_v[k] = m_v[k-1]; m_c[k] = m_c[k-1]; m_r[k] = m_r[k-1];
        end
        if (bub || !id_valid) begin
          m_v[1] = 0; m_c[1] = '0; m_r[1] = '0;
        end else begin
          m_v[1] = 1; m_c[1] = id_ctrl; m_r[1] = id_rd;
        end
        if (bub && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      chk_en = 1;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("stall_out", 32'(stall_out), 32'(m_stall()));
        check("fwd_rn_sel", 32'(fwd_rn_sel), 32'(m_sel(id_rn, id_rn_use)));
        check("fwd_rm_sel", 32'(fwd_rm_sel), 32'(m_sel(id_rm, id_rm_use)));
        check("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
        for (int k = 1; k <= DP; k++) begin
          check($sformatf("stg%0d_valid", k), 32'(stg_valid[k-1]), 32'(m_v[k]));
          check($sformatf("stg%0d_ctrl", k), 32'(stg_ctrl[k*CW-1 -: CW]), 32'(m_c[k]));
          check($sformatf("stg%0d_rd", k), 32'(stg_rd[k*RW-1 -: RW]), 32'(m_r[k]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(bit v, logic [CW-1:0] c, logic [RW-1:0] rd,
                        logic [RW-1:0] rn, bit rnu, logic [RW-1:0] rm, bit rmu, bit fl);
    id_valid = v; id_ctrl = c; id_rd = rd;
    id_rn = rn; id_rn_use = rnu; id_rm = rm; id_rm_use = rmu; flush = fl;
  endtask

  task automatic idle();
    set_id(0, '0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom), CW'($urandom), RW'($urandom), RW'($urandom), 1'($urandom),
           RW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    idle();
    repeat (DP) step();
  endtask

  initial begin
    // Reset held low for two edges with random inputs.
    reset = 1'b0;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    #1;
    check("rst_valid", 32'(stg_valid), 32'h0);
    check("rst_ctrl", 32'(stg_ctrl[31:0]), 32'h0);
    check("rst_rd", 32'(stg_rd), 32'h0);
    check("rst_cnt", 32'(bubble_cnt), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);
    check("rst_sel", 32'({fwd_rn_sel, fwd_rm_sel}), 32'h0);
    $display("reset: stages cleared, bubble_cnt=%0d", bubble_cnt);
    reset = 1'b1;
    idle();
    step();

    // Straight-line ALU forwarding and latency.
    set_id(1, 12'h002, 4'd3, 4'd0, 0, 4'd0, 0, 0);
    step();
    set_id(1, 12'h002, 4'd4, 4'd3, 1, 4'd0, 0, 0);
    #1;
    check("alu_fwd_rn", 32'(fwd_rn_sel), 32'd1);
    step();
    idle();
    #1;
    check("alu_stg3_early", 32'(stg_valid[2]), 32'd0);
    step();
    #1;
    check("alu_stg3_valid", 32'(stg_valid[2]), 32'd1);
    check("alu_stg3_rd", 32'(stg_rd[11:8]), 32'd3);
    $display("alu: rd3 reached stage 3, fwd_rn_sel was 1");
    drain();

    // Load-use: one bubble, then forward from stage 2.
    set_id(1, 12'h003, 4'd2, 4'd0, 0, 4'd0, 0, 0);
    step();
    set_id(1, 12'h002, 4'd5, 4'd2, 1, 4'd0, 0, 0);
    #1;
    check("lu_stall", 32'(stall_out), 32'd1);
    check("lu_sel_stalled", 32'(fwd_rn_sel), 32'd0);
    step();
    #1;
    check("lu_stg1_bubble", 32'(stg_valid[0]), 32'd0);
    check("lu_cnt", 32'(bubble_cnt), 32'd1);
    check("lu_stall_clear", 32'(stall_out), 32'd0);
    check("lu_fwd_rn", 32'(fwd_rn_sel), 32'd2);
    check("lu_stg2_ctrl", 32'(stg_ctrl[23:12]), 32'h003);
    $display("load-use: one bubble, then fwd_rn_sel=%0d", fwd_rn_sel);
    step();
    drain();

    // Youngest priority, non-load stage-1 writer.
    set_id(1, 12'h002, 4'd5, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h000, 4'd0, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h002, 4'd5, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h000, 4'd1, 4'd0, 0, 4'd5, 1, 0);
    #1;
    check("yp_fwd_rm", 32'(fwd_rm_sel), 32'd1);
    check("yp_stall", 32'(stall_out), 32'd0);
    $display("youngest: fwd_rm_sel=%0d", fwd_rm_sel);
    step();
    drain();

    // Youngest priority, stage-1 writer is a load; then flush the same cycle.
    set_id(1, 12'h002, 4'd5, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h000, 4'd0, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h003, 4'd5, 4'd0, 0, 4'd0, 0, 0); step();
    set_id(1, 12'h000, 4'd1, 4'd0, 0, 4'd5, 1, 0);
    #1;
    check("ypl_fwd_rm", 32'(fwd_rm_sel), 32'd0);
    check("ypl_stall", 32'(stall_out), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall_out), 32'd0);
    check("fl_fwd_rm", 32'(fwd_rm_sel), 32'd0);
    step();
    idle();
    #1;
    check("fl_stg1_bubble", 32'(stg_valid[0]), 32'd0);
    check("fl_stg2_ctrl", 32'(stg_ctrl[23:12]), 32'h003);
    check("fl_stg2_rd", 32'(stg_rd[7:4]), 32'd5);
    check("fl_stg3_valid", 32'(stg_valid[2]), 32'd1);
    check("fl_cnt", 32'(bubble_cnt), 32'd2);
    $display("flush+hazard: bubble_cnt=%0d", bubble_cnt);

    // Saturation: count starts at 2, reaches FFFE after 65532 flushes.
    set_id(0, '0, '0, '0, 0, '0, 0, 1);
    repeat (65532) step();
    #1;
    check("sat_fffe", 32'(bubble_cnt), 32'hFFFE);
    step();
    #1;
    check("sat_ffff", 32'(bubble_cnt), 32'hFFFF);
    repeat (4) step();
    #1;
    check("sat_hold", 32'(bubble_cnt), 32'hFFFF);
    $display("saturation: bubble_cnt=%0h", bubble_cnt);
    flush = 1'b0;
    reset = 1'b0;
    step();
    #1;
    check("sat_reset", 32'(bubble_cnt), 32'h0);
    reset = 1'b1;
    step();
    $display("reset after saturation: bubble_cnt=%0h", bubble_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
